i_decode: RTL
=============

// Module: i_decode
// PURPOSE
//  MIPS-style instruction decode stage; consumes IF_ID_instr/IF_ID_npc from fetch, produces ID/EX pipeline register.
//  Contains 32x32 register file (written back from MEM/WB), main control decoder, 16->32 sign extender.
//  All outputs registered; one ID/EX slot; EX_MEM_PCsrc flushes decode into a bubble.
// PARAMETERS
//  DATA_W  32  datapath/register width
//  REG_AW  5   register address width; register file depth = 2**REG_AW
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       synchronous, active-high
//  IF_ID_instr     in   32      instruction from fetch latch
//  IF_ID_npc       in   DATA_W  PC+4 from fetch latch
//  EX_MEM_PCsrc    in   1       branch taken; flush this decode slot
//  MEM_WB_regwrite in   1       write-back enable
//  MEM_WB_writereg in   REG_AW  write-back destination
//  WB_writedata    in   DATA_W  write-back data
//  ID_EX_wb        out  2       {RegWrite, MemtoReg}
//  ID_EX_m         out  3       {Branch, MemRead, MemWrite}
//  ID_EX_ex        out  4       {RegDst, ALUOp[1:0], ALUSrc}
//  ID_EX_npc       out  DATA_W  latched IF_ID_npc
//  ID_EX_readdat1  out  DATA_W  RF[instr[25:21]]
//  ID_EX_readdat2  out  DATA_W  RF[instr[20:16]]
//  ID_EX_signext   out  DATA_W  sign-extended instr[15:0]
//  ID_EX_rt        out  REG_AW  instr[20:16]
//  ID_EX_rd        out  REG_AW  instr[15:11]
// BEHAVIOUR
//  - Reset: all ID_EX_* outputs = 0; all RF entries = 0. Reset has priority over flush and write-back.
//  - Latency: 1 cycle; ID_EX_* at edge N+1 reflect IF_ID_* present before edge N+1. Latch updates every cycle (no stall).
//  - Control decode on opcode instr[31:26] (wb / m / ex):
//      0x00 R-type: 10 / 000 / 1_10_0
//      0x23 lw:     11 / 010 / 0_00_1
//      0x2B sw:     00 / 001 / 0_00_1
//      0x04 beq:    00 / 100 / 0_01_0
//      any other:   00 / 000 / 0_00_0 (NOP, datapath fields still latched)
//  - Flush: EX_MEM_PCsrc=1 at an edge -> wb/m/ex latched as 0; data fields latched normally.
//  - RF write: on rising edge when MEM_WB_regwrite=1 and MEM_WB_writereg!=0. Writes to r0 ignored; r0 always reads 0.
//  - RF reads combinational from current IF_ID_instr; no write-back forwarding: a same-edge write to a
//    register being read latches the OLD value into ID_EX_readdat*.
//  - Sign extend: ID_EX_signext = {{(DATA_W-16){instr[15]}}, instr[15:0]}.
//  - Reset deasserted mid-stream: first post-reset edge latches the live inputs normally.
// CONFIGURATION
//  WB_BYPASS_EN defined: if MEM_WB_regwrite=1, MEM_WB_writereg!=0 and equals rs (rt), ID_EX_readdat1
//    (readdat2) latches WB_writedata on that same edge (write-through). r0 never bypassed.
//  WB_BYPASS_EN undefined: no bypass; old value latched as above.
// TESTING
//  1. reset=1 two edges, then release -> all ID_EX_* = 0; read of every register = 0.
//  2. Write r5=0xDEADBEEF, then decode add (0x00A63020) with r6=0x00000001 -> readdat1=0xDEADBEEF,
//     readdat2=1, wb=10, m=000, ex=1100, rd=6, one cycle after instr presented.
//  3. lw 0x8C22FFFC -> wb=11, m=010, ex=0001, signext=0xFFFFFFFC, rt=2; sw 0xAC220010 -> m=001, signext=0x10.
//  4. beq decoded with EX_MEM_PCsrc=1 same edge -> wb/m/ex=0, npc still latched; unknown opcode 0x3F -> controls 0.
//  5. Write r0=0x1234 then read r0 -> 0; same-edge write r7=0xA5A5A5A5 while decoding rs=r7 -> old value
//     without WB_BYPASS_EN, 0xA5A5A5A5 with it.
//  6. Assert reset while regwrite=1 to r3 -> r3 stays 0, ID_EX_* cleared on that edge.

Source files
------------

// File: rtl/i_decode.sv
// i_decode: MIPS-style instruction decode stage with a single ID/EX pipeline register.
// Contents: a 32-entry register file written back from MEM/WB, the main control
// decoder and a 16->32 sign extender. Every output is registered.
// Optional feature macro: WB_BYPASS_EN. When it is defined, a write-back to rs/rt on
// the same edge is forwarded into ID_EX_readdat1/2. r0 is never forwarded.
module i_decode #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IF_ID_instr,
  input  logic [DATA_W-1:0] IF_ID_npc,
  input  logic              EX_MEM_PCsrc,
  input  logic              MEM_WB_regwrite,
  input  logic [REG_AW-1:0] MEM_WB_writereg,
  input  logic [DATA_W-1:0] WB_writedata,
  output logic [1:0]        ID_EX_wb,
  output logic [2:0]        ID_EX_m,
  output logic [3:0]        ID_EX_ex,
  output logic [DATA_W-1:0] ID_EX_npc,
  output logic [DATA_W-1:0] ID_EX_readdat1,
  output logic [DATA_W-1:0] ID_EX_readdat2,
  output logic [DATA_W-1:0] ID_EX_signext,
  output logic [REG_AW-1:0] ID_EX_rt,
  output logic [REG_AW-1:0] ID_EX_rd
);

  localparam int unsigned RF_DEPTH = 2 ** REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [DATA_W-1:0] rf_q [RF_DEPTH];

  logic [5:0]        opcode_c;
  logic [REG_AW-1:0] rs_c;
  logic [REG_AW-1:0] rt_c;
  logic [REG_AW-1:0] rd_c;
  logic [DATA_W-1:0] signext_c;
  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;
  logic [1:0]        wb_c;
  logic [2:0]        m_c;
  logic [3:0]        ex_c;
  logic              wb_en_c;

  assign opcode_c  = IF_ID_instr[31:26];
  assign rs_c      = REG_AW'(IF_ID_instr[25:21]);
  assign rt_c      = REG_AW'(IF_ID_instr[20:16]);
  assign rd_c      = REG_AW'(IF_ID_instr[15:11]);
  assign signext_c = {{(DATA_W-16){IF_ID_instr[15]}}, IF_ID_instr[15:0]};
  assign wb_en_c   = MEM_WB_regwrite && (MEM_WB_writereg != '0);

  // Register file: synchronous clear, write-back ignores r0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en_c) begin
      rf_q[MEM_WB_writereg] <= WB_writedata;
    end
  end

  // Operand read; r0 is forced to zero, optional same-edge write-through
  always_comb begin
    rd1_c = (rs_c == '0) ? '0 : rf_q[rs_c];
    rd2_c = (rt_c == '0) ? '0 : rf_q[rt_c];
`ifdef WB_BYPASS_EN
    if (wb_en_c && (MEM_WB_writereg == rs_c)) rd1_c = WB_writedata;
    if (wb_en_c && (MEM_WB_writereg == rt_c)) rd2_c = WB_writedata;
`else
`endif
  end

  // Main control decode; a taken branch in MEM squashes this slot into a bubble
  always_comb begin
    wb_c = 2'b00;
    m_c  = 3'b000;
    ex_c = 4'b0000;
    if (!EX_MEM_PCsrc) begin
      unique case (opcode_c)
        OP_RTYPE: begin wb_c = 2'b10; m_c = 3'b000; ex_c = 4'b1100; end
        OP_LW:    begin wb_c = 2'b11; m_c = 3'b010; ex_c = 4'b0001; end
        OP_SW:    begin wb_c = 2'b00; m_c = 3'b001; ex_c = 4'b0001; end
        OP_BEQ:   begin wb_c = 2'b00; m_c = 3'b100; ex_c = 4'b0010; end
        default:  begin wb_c = 2'b00; m_c = 3'b000; ex_c = 4'b0000; end
      endcase
    end
  end

  // ID/EX pipeline register, updated every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ID_EX_wb       <= '0;
      ID_EX_m        <= '0;
      ID_EX_ex       <= '0;
      ID_EX_npc      <= '0;
      ID_EX_readdat1 <= '0;
      ID_EX_readdat2 <= '0;
      ID_EX_signext  <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd       <= '0;
    end else begin
      ID_EX_wb       <= wb_c;
      ID_EX_m        <= m_c;
      ID_EX_ex       <= ex_c;
      ID_EX_npc      <= IF_ID_npc;
      ID_EX_readdat1 <= rd1_c;
      ID_EX_readdat2 <= rd2_c;
      ID_EX_signext  <= signext_c;
      ID_EX_rt       <= rt_c;
      ID_EX_rd       <= rd_c;
    end
  end

endmodule
